// File: rtl/npu_q_pkg.sv
// Shared constants and helpers for the NPU queue responder.
package npu_q_pkg;

    localparam int unsigned NPU_DATA_W    = 32;
    localparam int unsigned NPU_CFG_DEPTH = 8;
    localparam int unsigned NPU_IN_DEPTH  = 16;
    localparam int unsigned NPU_OUT_DEPTH = 16;

    // Occupancy counters hold 0..DEPTH, so they need one bit more than a pointer.
    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/npu_fifo_responder_if.sv
// NPU-core facing streams: config and data out to the NPU, results back in.
interface npu_fifo_responder_if
    import npu_q_pkg::*;
#(
    parameter int unsigned DATA_W = NPU_DATA_W
);

    logic [DATA_W-1:0] oCfgData;
    logic              oCfgValid;
    logic              iCfgReady;

    logic [DATA_W-1:0] oInData;
    logic              oInValid;
    logic              iInReady;

    logic [DATA_W-1:0] iOutData;
    logic              iOutValid;
    logic              oOutReady;

    // Queue side (the responder).
    modport slave (
        output oCfgData, oCfgValid,
        input  iCfgReady,
        output oInData, oInValid,
        input  iInReady,
        input  iOutData, iOutValid,
        output oOutReady
    );

    // NPU core side.
    modport master (
        input  oCfgData, oCfgValid,
        output iCfgReady,
        input  oInData, oInValid,
        output iInReady,
        output iOutData, iOutValid,
        input  oOutReady
    );

endinterface

// File: rtl/npu_sync_fifo.sv
// Show-ahead synchronous FIFO; head is zero when empty.
module npu_sync_fifo
    import npu_q_pkg::*;
#(
    parameter int unsigned W     = NPU_DATA_W,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [occ_w(DEPTH)-1:0]  count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = occ_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally (DEPTH is a power of 2); count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array; contents are discarded on reset by clearing the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/npu_fifo_responder.sv
// NPU-side end of the EX queue interface: cfg/data FIFOs toward the NPU,
// result FIFO back to EX, plus the EX stall and the sticky overflow flag.
module npu_fifo_responder
    import npu_q_pkg::*;
#(
    parameter int unsigned DATA_W    = NPU_DATA_W,
    parameter int unsigned CFG_DEPTH = NPU_CFG_DEPTH,
    parameter int unsigned IN_DEPTH  = NPU_IN_DEPTH,
    parameter int unsigned OUT_DEPTH = NPU_OUT_DEPTH
) (
    input  logic                         iClk,
    input  logic                         iRst_n,
    input  logic [DATA_W-1:0]            iNpuConfigFifo,
    input  logic                         iNpuConfigWe,
    input  logic [DATA_W-1:0]            iNpuDataFifo,
    input  logic                         iNpuDataWe,
    input  logic                         iNpuDataRe,
    output logic [DATA_W-1:0]            oNpuDataFifo,
    output logic                         oNpuStall,
    npu_fifo_responder_if.slave          npu,
    output logic [occ_w(CFG_DEPTH)-1:0]  oCfgCount,
    output logic [occ_w(IN_DEPTH)-1:0]   oInCount,
    output logic [occ_w(OUT_DEPTH)-1:0]  oOutCount,
    output logic                         oOverflowErr
);

    logic cfg_full, cfg_empty;
    logic in_full, in_empty;
    logic out_full, out_empty;
    logic ready_live;
    logic out_push;

    // Stall is all-or-nothing: any unserviceable request blocks every EX push/pop this cycle.
    assign oNpuStall = (iNpuConfigWe & cfg_full) | (iNpuDataWe & in_full) | (iNpuDataRe & out_empty);

    assign npu.oCfgValid = ~cfg_empty;
    assign npu.oInValid  = ~in_empty;
    assign npu.oOutReady = ready_live & ~out_full;
    assign out_push      = npu.iOutValid & npu.oOutReady;

    npu_sync_fifo #(.W(DATA_W), .DEPTH(CFG_DEPTH)) u_cfg_fifo (
        .clk   (iClk),
        .rst_n (iRst_n),
        .push  (iNpuConfigWe & ~oNpuStall),
        .pop   (npu.oCfgValid & npu.iCfgReady),
        .wdata (iNpuConfigFifo),
        .head  (npu.oCfgData),
        .full  (cfg_full),
        .empty (cfg_empty),
        .count (oCfgCount)
    );

    npu_sync_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (iClk),
        .rst_n (iRst_n),
        .push  (iNpuDataWe & ~oNpuStall),
        .pop   (npu.oInValid & npu.iInReady),
        .wdata (iNpuDataFifo),
        .head  (npu.oInData),
        .full  (in_full),
        .empty (in_empty),
        .count (oInCount)
    );

    npu_sync_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (iClk),
        .rst_n (iRst_n),
        .push  (out_push),
        .pop   (iNpuDataRe & ~oNpuStall),
        .wdata (npu.iOutData),
        .head  (oNpuDataFifo),
        .full  (out_full),
        .empty (out_empty),
        .count (oOutCount)
    );

    // Result-side ready is held low during reset and opens on the first clock after release.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) ready_live <= 1'b0;
        else         ready_live <= 1'b1;
    end

    // Sticky overflow: NPU offered a result while the output FIFO was full (word is dropped).
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)                        oOverflowErr <= 1'b0;
        else if (npu.iOutValid & out_full)  oOverflowErr <= 1'b1;
    end

endmodule
